// File: rtl/display_page_scheduler.sv
// display_page_scheduler
//   Chooses the page shown on the 4-digit parking display and converts it to
//   BCD for the digit-scan driver. Three page sources compete: alarm page,
//   fee page (requested by exit logic) and the periodic status page. Each page
//   runs one or two 8-bit operands through an iterative double-dabble
//   converter, is published for one cycle with disp_valid, then held.
//
//   Parameters:
//     REFRESH_TICKS  cycles between status-page refreshes (2..65535)
//     FEE_DWELL      cycles the fee page is held (2..65535)
//     BLINK_TICKS    half-period of the alarm-page blink (1..65535)
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     vehicle_count     vehicles currently parked (6 bits)
//     available_spaces  free spaces (6 bits)
//     fee_amount        fee in whole units (8 bits)
//     fee_req           single-cycle request to show fee_amount
//     alarm             alarm level
//     current_state     parking FSM state code (3 bits)
//     disp_bcd          digits {d3,d2,d1,d0}, d0 rightmost
//     blank_mask        1 = digit blanked, bit i maps to digit i
//     disp_valid        one-cycle pulse when disp_bcd/blank_mask update
//     page_id           0 = status, 1 = fee, 2 = alarm
//     busy              high while a page is being loaded/converted/published
//
//   Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros within
//   each field of the status and fee pages.
module display_page_scheduler #(
  parameter int REFRESH_TICKS = 1000,
  parameter int FEE_DWELL     = 5000,
  parameter int BLINK_TICKS   = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  vehicle_count,
  input  logic [5:0]  available_spaces,
  input  logic [7:0]  fee_amount,
  input  logic        fee_req,
  input  logic        alarm,
  input  logic [2:0]  current_state,
  output logic [15:0] disp_bcd,
  output logic [3:0]  blank_mask,
  output logic        disp_valid,
  output logic [1:0]  page_id,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, CONV, PUB, HOLD} state_t;

  localparam logic [1:0] PG_STATUS = 2'd0;
  localparam logic [1:0] PG_FEE    = 2'd1;
  localparam logic [1:0] PG_ALARM  = 2'd2;

  localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_TICKS - 1);
  localparam logic [15:0] DWELL_MAX   = 16'(FEE_DWELL - 1);
  localparam logic [15:0] BLINK_MAX   = 16'(BLINK_TICKS - 1);

  state_t      state;
  logic [1:0]  page_sel;
  logic        second_op;     // status page: converting vehicle_count
  logic [2:0]  conv_cnt;
  logic [19:0] shift_reg;     // {hundreds, tens, ones, binary}
  logic [7:0]  spaces_bcd;    // tens:ones of available_spaces
  logic [15:0] refresh_cnt;
  logic [15:0] dwell_cnt;
  logic [15:0] blink_cnt;
  logic        fee_pending;
  logic        status_req;    // status owed right after reset / alarm clear

  logic [19:0] shift_nxt;
  logic [7:0]  operand;
  logic [15:0] pub_bcd;
  logic [3:0]  pub_mask;
  logic        in_flight;
  logic        status_in_flight;
  logic        preempt;

  // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[8 + 4*i +: 4] >= 4'd5)
        a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign shift_nxt        = dd_step(shift_reg);
  assign in_flight        = (state == LOAD) || (state == CONV) || (state == PUB);
  assign status_in_flight = in_flight && (page_sel == PG_STATUS);
  assign preempt          = in_flight && alarm && (page_sel != PG_ALARM);

  always_comb begin
    operand = 8'h00;
    case (page_sel)
      PG_STATUS: operand = second_op ? {2'b00, vehicle_count} : {2'b00, available_spaces};
      PG_FEE:    operand = fee_amount;
      PG_ALARM:  operand = {5'b00000, current_state};
      default:   operand = 8'h00;
    endcase
  end

  // Page layout, built from the result of the final conversion step.
  always_comb begin
    pub_bcd  = 16'h0000;
    pub_mask = 4'b1111;
    case (page_sel)
      PG_STATUS: begin
        pub_bcd = {shift_nxt[15:8], spaces_bcd};
`ifdef LEADING_ZERO_BLANK_EN
        pub_mask = {shift_nxt[15:12] == 4'd0, 1'b0, spaces_bcd[7:4] == 4'd0, 1'b0};
`else
        pub_mask = 4'b0000;
`endif
      end
      PG_FEE: begin
        pub_bcd = {4'h0, shift_nxt[19:8]};
`ifdef LEADING_ZERO_BLANK_EN
        pub_mask = {1'b1, shift_nxt[19:16] == 4'd0, shift_nxt[19:12] == 8'd0, 1'b0};
`else
        pub_mask = 4'b1000;
`endif
      end
      PG_ALARM: begin
        pub_bcd  = {12'h000, shift_nxt[11:8]};
        pub_mask = 4'b1110;
      end
      default: begin
        pub_bcd  = 16'h0000;
        pub_mask = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      page_sel    <= PG_STATUS;
      second_op   <= 1'b0;
      conv_cnt    <= 3'd0;
      shift_reg   <= 20'h00000;
      spaces_bcd  <= 8'h00;
      refresh_cnt <= 16'd0;
      dwell_cnt   <= 16'd0;
      blink_cnt   <= 16'd0;
      fee_pending <= 1'b0;
      status_req  <= 1'b1;
      disp_bcd    <= 16'h0000;
      blank_mask  <= 4'b1111;
      disp_valid  <= 1'b0;
      page_id     <= PG_STATUS;
      busy        <= 1'b0;
    end else begin
      disp_valid <= 1'b0;

      // A fee grant below overrides this set in the same cycle.
      if (fee_req)
        fee_pending <= 1'b1;

      // Refresh timer restarts on status publish and saturates while waiting.
      if (state == PUB && page_sel == PG_STATUS)
        refresh_cnt <= 16'd0;
      else if (!status_in_flight && refresh_cnt != REFRESH_MAX)
        refresh_cnt <= refresh_cnt + 16'd1;

      // Alarm blink runs from the publish cycle on.
      if ((state == PUB || state == HOLD) && page_sel == PG_ALARM) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt     <= 16'd0;
          blank_mask[0] <= ~blank_mask[0];
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end

      if (preempt) begin
        state     <= LOAD;
        page_sel  <= PG_ALARM;
        second_op <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            second_op <= 1'b0;
            if (alarm) begin
              page_sel <= PG_ALARM;
              state    <= LOAD;
              busy     <= 1'b1;
            end else if (fee_pending || fee_req) begin
              page_sel    <= PG_FEE;
              fee_pending <= 1'b0;
              state       <= LOAD;
              busy        <= 1'b1;
            end else if (status_req || refresh_cnt == REFRESH_MAX) begin
              page_sel   <= PG_STATUS;
              status_req <= 1'b0;
              state      <= LOAD;
              busy       <= 1'b1;
            end
          end
          LOAD: begin
            shift_reg <= {12'h000, operand};
            conv_cnt  <= 3'd0;
            state     <= CONV;
          end
          CONV: begin
            shift_reg <= shift_nxt;
            conv_cnt  <= conv_cnt + 3'd1;
            if (conv_cnt == 3'd7) begin
              if (page_sel == PG_STATUS && !second_op) begin
                spaces_bcd <= shift_nxt[15:8];
                second_op  <= 1'b1;
                state      <= LOAD;
              end else begin
                disp_bcd   <= pub_bcd;
                blank_mask <= pub_mask;
                page_id    <= page_sel;
                disp_valid <= 1'b1;
                dwell_cnt  <= 16'd0;
                blink_cnt  <= 16'd0;
                state      <= PUB;
              end
            end
          end
          PUB: begin
            busy  <= 1'b0;
            state <= HOLD;
          end
          HOLD: begin
            case (page_sel)
              PG_FEE: begin
                if (alarm || dwell_cnt == DWELL_MAX)
                  state <= IDLE;
                else
                  dwell_cnt <= dwell_cnt + 16'd1;
              end
              PG_ALARM: begin
                if (!alarm) begin
                  status_req <= 1'b1;
                  state      <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_page_scheduler.sv
// Testbench for display_page_scheduler: table of fee/status pages, directed
// sequences for reset, latency, alarm preemption/blink and arbitration, then
// randomized pages checked against a decimal-arithmetic reference model.
module tb_display_page_scheduler;

  localparam int REFRESH_TICKS = 40;
  localparam int FEE_DWELL     = 30;
  localparam int BLINK_TICKS   = 6;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [5:0]  vehicle_count;
  logic [5:0]  available_spaces;
  logic [7:0]  fee_amount;
  logic        fee_req;
  logic        alarm;
  logic [2:0]  current_state;
  logic [15:0] disp_bcd;
  logic [3:0]  blank_mask;
  logic        disp_valid;
  logic [1:0]  page_id;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  display_page_scheduler #(
    .REFRESH_TICKS(REFRESH_TICKS),
    .FEE_DWELL    (FEE_DWELL),
    .BLINK_TICKS  (BLINK_TICKS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .vehicle_count   (vehicle_count),
    .available_spaces(available_spaces),
    .fee_amount      (fee_amount),
    .fee_req         (fee_req),
    .alarm           (alarm),
    .current_state   (current_state),
    .disp_bcd        (disp_bcd),
    .blank_mask      (blank_mask),
    .disp_valid      (disp_valid),
    .page_id         (page_id),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          is_fee;
    int          fee;
    int          sp;
    int          cnt;
    int          exp_page;
    logic [15:0] exp_bcd;
    logic [3:0]  mask_off;
    logic [3:0]  mask_on;
  } vec_t;

  vec_t tbl [10];

  // Reference model: decimal digits from plain arithmetic.
  function automatic logic [15:0] status_word(input int sp, input int cnt);
    return {4'(cnt / 10), 4'(cnt % 10), 4'(sp / 10), 4'(sp % 10)};
  endfunction

  function automatic logic [15:0] fee_word(input int f);
    return {4'h0, 4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
  endfunction

  function automatic logic [3:0] status_mask(input int sp, input int cnt);
    return LZ ? {cnt < 10, 1'b0, sp < 10, 1'b0} : 4'b0000;
  endfunction

  function automatic logic [3:0] fee_mask(input int f);
    return LZ ? {1'b1, f < 100, f < 10, 1'b0} : 4'b1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next disp_valid; fee_req is released after the first edge.
  task automatic wait_valid(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      fee_req = 1'b0;
      if (disp_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: no disp_valid within %0d cycles", budget);
    end
  endtask

  task automatic check_page(input string name, input int pg, input logic [15:0] bcd,
                            input logic [3:0] mask);
    check({name, "_page"}, 32'(page_id), 32'(pg));
    check({name, "_bcd"},  32'(disp_bcd), 32'(bcd));
    check({name, "_mask"}, 32'(blank_mask), 32'(mask));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_bcd"},   32'(disp_bcd), 32'h0);
    check({name, "_mask"},  32'(blank_mask), 32'hF);
    check({name, "_valid"}, 32'(disp_valid), 32'h0);
    check({name, "_page"},  32'(page_id), 32'h0);
    check({name, "_busy"},  32'(busy), 32'h0);
  endtask

  initial begin
    int cyc;
    int n;
    int vcount;
    int sp;
    int cnt;
    int f;
    bit do_fee;

    tbl[0] = '{1'b1,   0,  0,  0, 1, 16'h0000, 4'b1000, 4'b1110};
    tbl[1] = '{1'b0,   0,  5,  0, 0, 16'h0005, 4'b0000, 4'b1010};
    tbl[2] = '{1'b1,   7,  5,  0, 1, 16'h0007, 4'b1000, 4'b1110};
    tbl[3] = '{1'b1,  99,  5,  0, 1, 16'h0099, 4'b1000, 4'b1100};
    tbl[4] = '{1'b0,   0, 63, 63, 0, 16'h6363, 4'b0000, 4'b0000};
    tbl[5] = '{1'b1, 100, 63, 63, 1, 16'h0100, 4'b1000, 4'b1000};
    tbl[6] = '{1'b1, 255, 63, 63, 1, 16'h0255, 4'b1000, 4'b1000};
    tbl[7] = '{1'b0,   0,  0, 10, 0, 16'h1000, 4'b0000, 4'b0010};
    tbl[8] = '{1'b0,   0, 10,  9, 0, 16'h0910, 4'b0000, 4'b1000};
    tbl[9] = '{1'b1,  10, 10,  9, 1, 16'h0010, 4'b1000, 4'b1100};

    reset            = 1'b1;
    fee_req          = 1'b0;
    alarm            = 1'b0;
    current_state    = 3'd0;
    fee_amount       = 8'd0;
    available_spaces = 6'd37;
    vehicle_count    = 6'd12;

    // Reset state, then the status page granted straight out of reset.
    skip(3);
    check_reset_values("reset");
    reset = 1'b0;
    wait_valid(40, cyc);
    check("status_latency", 32'(cyc), 32'd19);
    check_page("status_first", 0, 16'h1237, 4'b0000);
    @(negedge clk);
    check("valid_pulse_width", 32'(disp_valid), 32'h0);

    // Fee page from IDLE: 10-cycle latency, then dwell before status.
    skip(3);
    fee_amount = 8'd205;
    fee_req    = 1'b1;
    wait_valid(40, cyc);
    check("fee_latency", 32'(cyc), 32'd10);
    check_page("fee_205", 1, 16'h0205, fee_mask(205));
    wait_valid(200, cyc);
    check("fee_dwell_respected", 32'(cyc >= FEE_DWELL + 20), 32'd1);
    check_page("status_after_fee", 0, 16'h1237, 4'b0000);

    // Table of fee and status pages.
    for (int i = 0; i < 10; i++) begin
      available_spaces = 6'(tbl[i].sp);
      vehicle_count    = 6'(tbl[i].cnt);
      fee_amount       = 8'(tbl[i].fee);
      if (tbl[i].is_fee) fee_req = 1'b1;
      wait_valid(300, cyc);
      check_page($sformatf("tbl%0d", i), tbl[i].exp_page, tbl[i].exp_bcd,
                 LZ ? tbl[i].mask_on : tbl[i].mask_off);
    end

    // Alarm rising four cycles into a status conversion.
    available_spaces = 6'd42;
    vehicle_count    = 6'd17;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 200);
    check("status_busy_seen", 32'(n < 200), 32'd1);
    skip(4);
    alarm         = 1'b1;
    current_state = 3'd7;
    wait_valid(40, cyc);
    check("alarm_latency", 32'(cyc), 32'd10);
    check_page("alarm_7", 2, 16'h0007, 4'b1110);
    vcount = 0;
    for (int k = 1; k < 4 * BLINK_TICKS; k++) begin
      @(negedge clk);
      if (disp_valid === 1'b1) vcount++;
      check($sformatf("blink_k%0d", k), 32'(blank_mask),
            32'(((k / BLINK_TICKS) % 2 == 0) ? 4'b1110 : 4'b1111));
    end
    check("blink_no_valid", 32'(vcount), 32'd0);
    alarm = 1'b0;
    wait_valid(100, cyc);
    check_page("status_after_alarm", 0, 16'h1742, status_mask(42, 17));

    // Alarm and fee_req in the same IDLE cycle.
    available_spaces = 6'd21;
    vehicle_count    = 6'd34;
    skip(3);
    alarm         = 1'b1;
    fee_req       = 1'b1;
    fee_amount    = 8'd99;
    current_state = 3'd3;
    wait_valid(40, cyc);
    check_page("combo_alarm", 2, 16'h0003, 4'b1110);
    skip(10);
    alarm = 1'b0;
    wait_valid(100, cyc);
    check_page("combo_fee", 1, 16'h0099, fee_mask(99));
    wait_valid(200, cyc);
    check_page("combo_status", 0, 16'h3421, status_mask(21, 34));

    // Reset in the middle of a fee conversion.
    skip(3);
    fee_amount = 8'd123;
    fee_req    = 1'b1;
    @(negedge clk);
    fee_req = 1'b0;
    skip(4);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midconv_reset");
    reset = 1'b0;
    wait_valid(40, cyc);
    check("post_reset_latency", 32'(cyc), 32'd19);
    check_page("post_reset_status", 0, 16'h3421, status_mask(21, 34));

    // Randomized pages against the reference model.
    for (int it = 0; it < 40; it++) begin
      sp     = int'($urandom_range(0, 63));
      cnt    = int'($urandom_range(0, 63));
      f      = int'($urandom_range(0, 255));
      do_fee = 1'($urandom_range(0, 1));
      available_spaces = 6'(sp);
      vehicle_count    = 6'(cnt);
      fee_amount       = 8'(f);
      fee_req          = do_fee;
      wait_valid(300, cyc);
      if (do_fee)
        check_page($sformatf("rnd%0d_fee", it), 1, fee_word(f), fee_mask(f));
      else
        check_page($sformatf("rnd%0d_status", it), 0, status_word(sp, cnt),
                   status_mask(sp, cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_page_scheduler.md
Name: display_page_scheduler

Overview:
- Decides what the 4-digit parking display shows and converts it to BCD for the digit-scan driver.
- Arbitrates three page sources: alarm page, fee page (requested by exit logic), and the periodic status page.
- Runs an iterative binary-to-BCD converter, publishes one 16-bit digit word plus blank mask per page update, and holds each page for a dwell time.
- Sits between the parking FSM/fee calculator and the display driver.

Parameters:
- REFRESH_TICKS, 1000: cycles between status-page refreshes. Range 2..65535.
- FEE_DWELL, 5000: cycles the fee page is held before status resumes. Range 2..65535.
- BLINK_TICKS, 500: half-period of the alarm-page blink. Range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active high
- vehicle_count  in  6  vehicles currently parked
- available_spaces  in  6  free spaces
- fee_amount  in  8  fee in whole units, 0..255
- fee_req  in  1  single-cycle pulse: show fee_amount
- alarm  in  1  level: alarm active
- current_state  in  3  parking FSM state code
- disp_bcd  out  16  digits {d3,d2,d1,d0}, 4 bits each, d0 rightmost
- blank_mask  out  4  1 = digit blanked; bit i maps to digit i
- disp_valid  out  1  one-cycle pulse when disp_bcd/blank_mask update
- page_id  out  2  0 = status, 1 = fee, 2 = alarm
- busy  out  1  high while in LOAD, CONV or PUB

Behaviour:
- Reset values: disp_bcd = 0, blank_mask = 4'b1111, disp_valid = 0, page_id = 0, busy = 0, fee_pending = 0, all timers = 0, state = IDLE. Reset mid-conversion aborts the conversion and nothing is published.
- States: IDLE, LOAD, CONV, PUB, HOLD.
- Arbitration is evaluated in IDLE only. Priority: alarm > fee_pending > status.
- Status is granted when refresh_cnt reaches REFRESH_TICKS-1, or immediately after reset.
- fee_req sets fee_pending in any state. fee_pending clears when the fee page is granted. A second fee_req while pending is absorbed; the latest fee_amount is sampled at LOAD.
- LOAD (1 cycle): shift register = {12'b0, operand}; busy = 1.
- CONV (8 cycles): double-dabble. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left 1. After 8 cycles the result is 3 BCD digits, always ≤ 255.
- Status page runs two operands: available_spaces, then vehicle_count.
  - Sequence is LOAD, CONV×8, LOAD, CONV×8, PUB.
  - Layout: d1:d0 = spaces (tens:ones), d3:d2 = count (tens:ones).
- Fee page runs one operand. Layout: d2:d1:d0 = hundreds:tens:ones, d3 = 0 with blank_mask[3] = 1.
- Alarm page runs one operand, {5'b0, current_state}. Layout: d0 = state code, d3..d1 = 0, blank_mask = 4'b1110.
- Latency from grant cycle to disp_valid:
  - fee page: 10 cycles (1 LOAD + 8 CONV + 1 PUB)
  - alarm page: 10 cycles
  - status page: 19 cycles (1 + 8 + 1 + 8 + 1)
- PUB (1 cycle): registers disp_bcd, blank_mask and page_id; disp_valid = 1 for exactly this cycle. Then go to HOLD.
- HOLD behaviour by page:
  - status: return to IDLE immediately; refresh_cnt restarts from 0 at PUB.
  - fee: stay FEE_DWELL cycles, then go to IDLE. fee_req during the dwell sets fee_pending, so the fee page is re-shown after the dwell.
  - alarm: stay while alarm = 1. blink_cnt toggles blank_mask[0] every BLINK_TICKS cycles; no disp_valid pulses during blinking. On alarm falling, go to IDLE and the status page is granted next (fee_pending, if set, outranks it).
- Alarm preemption: alarm rising during LOAD/CONV/PUB of a non-alarm page aborts it next cycle. Go to LOAD of the alarm page with no disp_valid for the aborted page. fee_pending is retained. Alarm rising during the fee HOLD ends the dwell and goes to IDLE next cycle.
- refresh_cnt counts only while no status page is in flight. It saturates at REFRESH_TICKS-1 while a higher-priority page owns the display.
- Simultaneous alarm and fee_req in IDLE: alarm is granted and fee_pending is set.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading zeros are blanked within each field. Status: d1 blanked if spaces < 10; d3 blanked if count < 10. Fee: d2 blanked if < 100; d1 blanked if < 10. The ones digit is never blanked.
- Undefined: zeros are shown. blank_mask is 0000 for status and 1000 for fee.
- The alarm page is identical with or without the macro.

Test Plan:
- Reset, then run with spaces = 37, count = 12 → first disp_valid 19 cycles after the grant; disp_bcd = 16'h1237, page_id = 0, blank_mask = 0000.
- fee_req pulse with fee_amount = 205 while IDLE → disp_valid 10 cycles later; disp_bcd = 16'h0205, blank_mask = 1000, page_id = 1; next status grant no earlier than FEE_DWELL cycles after PUB.
- alarm rises 4 cycles into a status CONV with current_state = 7 → no status disp_valid; disp_bcd = 16'h0007, page_id = 2; blank_mask alternates 1110/1111 every BLINK_TICKS cycles; alarm falls → status page published.
- fee_req and alarm in the same IDLE cycle, fee_amount = 99 → alarm page first; after alarm drops, fee page 16'h0099 shown before status.
- LEADING_ZERO_BLANK_EN defined, spaces = 5, count = 0, fee = 7 → status blank_mask = 1010; fee blank_mask = 1110.
- Reset asserted mid-CONV of a fee page → the next cycle shows all outputs at reset values and no disp_valid.
